// File: rtl/io_pkg.sv
// io_pkg: shared constants and helpers for the memory-mapped I/O peripheral.
//
// Contents:
//   - word addresses of the output (256..319) and input (320..383) windows
//   - HEX register width/reset value (depends on IO_HEX_DECODE_EN)
//   - hex_to_seg(): 4-bit nibble to active-low 7-segment pattern (bit 0 = seg a)
//
// Configuration macro: IO_HEX_DECODE_EN
//   defined   -> HEX registers hold {blank, nibble} (5 bits), decoded on output
//   undefined -> HEX registers hold raw active-low segments (7 bits)

package io_pkg;

    localparam logic [31:0] IO_OUT_BASE     = 32'd256;
    localparam logic [31:0] IO_IN_END       = 32'd383;
    localparam logic [31:0] IO_LEDR_ADDR    = 32'd256;
    localparam logic [31:0] IO_LEDG_ADDR    = 32'd257;
    localparam logic [31:0] IO_HEX0_ADDR    = 32'd258;
    localparam logic [31:0] IO_HEX7_ADDR    = IO_HEX0_ADDR + 32'd7;
    localparam logic [31:0] IO_SW_ADDR      = 32'd320;
    localparam logic [31:0] IO_KEY_ADDR     = 32'd321;
    localparam logic [31:0] IO_KEYEDGE_ADDR = 32'd322;

    localparam int unsigned IO_HEX_NUM = 8;

`ifdef IO_HEX_DECODE_EN
    localparam int unsigned          IO_HEX_W   = 5;
    localparam logic [IO_HEX_W-1:0]  IO_HEX_RST = 5'h10;
`else
    localparam int unsigned          IO_HEX_W   = 7;
    localparam logic [IO_HEX_W-1:0]  IO_HEX_RST = 7'h7F;
`endif

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// io_debounce: per-bit 2-flop synchronizer followed by a stability counter.
//
// A debounced bit only takes the synchronized value after it has differed from
// the current debounced value for DEBOUNCE_CYCLES consecutive cycles; any cycle
// where they agree restarts the count.
//
// Parameters: WIDTH, DEBOUNCE_CYCLES (1..65535), RESET_VAL (debounced/sync reset)
// Ports:
//   clk_i  in  1      system clock
//   rst_i  in  1      asynchronous active-high reset
//   raw_i  in  WIDTH  raw asynchronous inputs
//   deb_o  out WIDTH  debounced outputs

module io_debounce #(
    parameter int unsigned       WIDTH           = 1,
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0]  RESET_VAL       = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] deb_o
);

    // Compare against N-1 so the update lands on the N-th mismatching edge.
    localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic        deb_q;
        logic [15:0] cnt_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                deb_q <= RESET_VAL[i];
                cnt_q <= '0;
            end else if (sync2_q[i] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                deb_q <= sync2_q[i];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign deb_o[i] = deb_q;
    end

endmodule

// File: rtl/io_periph.sv
// io_periph: memory-mapped LED / 7-segment outputs and debounced switch / key
// inputs, decoding word addresses 256..383 of the data address map.
//
// Configuration macro: IO_HEX_DECODE_EN (see io_pkg) selects nibble-decoded
// HEX registers instead of raw segment registers.
//
// Ports:
//   clk_i    in  1      system clock
//   rst_i    in  1      asynchronous active-high reset
//   addr_i   in  32     word address
//   dataW_i  in  32     store data
//   MemRW_i  in  1      1 = store this cycle
//   sw_i     in  SW_W   raw switches, active-high
//   key_i    in  KEY_W  raw keys, active-low
//   dataR_o  out 32     load data, 0 outside the window
//   sel_o    out 1      address lies in 256..383
//   ledr_o   out 18     red LEDs
//   ledg_o   out 8      green LEDs
//   hex_o    out 56     eight active-low digits, digit n at [7n+6:7n]

module io_periph
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned KEY_W           = 4,
    parameter int unsigned SW_W            = 18
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       dataW_i,
    input  logic              MemRW_i,
    input  logic [SW_W-1:0]   sw_i,
    input  logic [KEY_W-1:0]  key_i,
    output logic [31:0]       dataR_o,
    output logic              sel_o,
    output logic [17:0]       ledr_o,
    output logic [7:0]        ledg_o,
    output logic [55:0]       hex_o
);

    logic [SW_W-1:0]     sw_deb;
    logic [KEY_W-1:0]    key_deb;
    logic [KEY_W-1:0]    key_prev_q;
    logic [KEY_W-1:0]    key_fall, key_clr;
    logic [KEY_W-1:0]    keyedge_q, keyedge_d;
    logic [17:0]         ledr_q, ledr_d;
    logic [7:0]          ledg_q, ledg_d;
    logic [IO_HEX_W-1:0] hex_q [IO_HEX_NUM];
    logic [IO_HEX_W-1:0] hex_d [IO_HEX_NUM];
    logic                in_hex;
    logic [2:0]          hex_idx;
    logic                unused_dataw;

    assign unused_dataw = ^dataW_i[31:18];

    io_debounce #(
        .WIDTH           (SW_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       ({SW_W{1'b0}})
    ) u_sw_deb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .raw_i (sw_i),
        .deb_o (sw_deb)
    );

    io_debounce #(
        .WIDTH           (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       ({KEY_W{1'b1}})
    ) u_key_deb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .raw_i (key_i),
        .deb_o (key_deb)
    );

    assign sel_o  = (addr_i >= IO_OUT_BASE) && (addr_i <= IO_IN_END);
    assign in_hex = (addr_i >= IO_HEX0_ADDR) && (addr_i <= IO_HEX7_ADDR);
    // The eight HEX words are contiguous, so the low address bits minus the
    // base's low bits give the digit index modulo 8.
    assign hex_idx = addr_i[2:0] - IO_HEX0_ADDR[2:0];

    // Keys are active-low: a debounced 1->0 step is a press.
    assign key_fall = key_prev_q & ~key_deb;
    assign key_clr  = (MemRW_i && (addr_i == IO_KEYEDGE_ADDR)) ? dataW_i[KEY_W-1:0] : '0;
    // Set after clear so a press coinciding with a W1C store is not lost.
    assign keyedge_d = (keyedge_q & ~key_clr) | key_fall;

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        hex_d  = hex_q;
        if (MemRW_i) begin
            if (addr_i == IO_LEDR_ADDR) ledr_d = dataW_i[17:0];
            if (addr_i == IO_LEDG_ADDR) ledg_d = dataW_i[7:0];
            if (in_hex) hex_d[hex_idx] = dataW_i[IO_HEX_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hex_q      <= '{default: IO_HEX_RST};
            keyedge_q  <= '0;
            key_prev_q <= '1;
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hex_q      <= hex_d;
            keyedge_q  <= keyedge_d;
            key_prev_q <= key_deb;
        end
    end

    // Loads read current register state, so a same-cycle store is not seen.
    always_comb begin
        dataR_o = '0;
        if (addr_i == IO_LEDR_ADDR) begin
            dataR_o = 32'(ledr_q);
        end else if (addr_i == IO_LEDG_ADDR) begin
            dataR_o = 32'(ledg_q);
        end else if (in_hex) begin
            dataR_o = 32'(hex_q[hex_idx]);
        end else if (addr_i == IO_SW_ADDR) begin
            dataR_o = 32'(sw_deb);
        end else if (addr_i == IO_KEY_ADDR) begin
            dataR_o = 32'(key_deb);
        end else if (addr_i == IO_KEYEDGE_ADDR) begin
            dataR_o = 32'(keyedge_q);
        end
    end

    assign ledr_o = ledr_q;
    assign ledg_o = ledg_q;

    always_comb begin
        hex_o = '1;
        for (int n = 0; n < IO_HEX_NUM; n++) begin
`ifdef IO_HEX_DECODE_EN
            hex_o[7*n +: 7] = hex_q[n][4] ? 7'h7F : hex_to_seg(hex_q[n][3:0]);
`else
            hex_o[7*n +: 7] = hex_q[n];
`endif
        end
    end

endmodule

// File: tb/tb_io_periph.sv
// Self-checking bench for io_periph: directed steps followed by a randomized
// phase, all checked against a behavioural model of the register map and of
// the input path ("a debounced bit flips once the last N synchronized samples
// all disagree with it").

module tb_io_periph;

    localparam int N    = 16;
    localparam int KW   = 4;
    localparam int SWW  = 18;
`ifdef IO_HEX_DECODE_EN
    localparam logic [6:0] HEX_RST  = 7'h10;
    localparam logic [6:0] HEX_MASK = 7'h1F;
`else
    localparam logic [6:0] HEX_RST  = 7'h7F;
    localparam logic [6:0] HEX_MASK = 7'h7F;
`endif
    localparam logic [21:0] DEB_RST = {4'hF, 18'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr, dataw;
    logic          memrw;
    logic [SWW-1:0] sw;
    logic [KW-1:0] key;
    logic [31:0]   dataR;
    logic          sel;
    logic [17:0]   ledr;
    logic [7:0]    ledg;
    logic [55:0]   hex;

    always #5 clk = ~clk;

    io_periph #(
        .DEBOUNCE_CYCLES (N),
        .KEY_W           (KW),
        .SW_W            (SWW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr),
        .dataW_i (dataw),
        .MemRW_i (memrw),
        .sw_i    (sw),
        .key_i   (key),
        .dataR_o (dataR),
        .sel_o   (sel),
        .ledr_o  (ledr),
        .ledg_o  (ledg),
        .hex_o   (hex)
    );

    // Reference model state.
    logic [17:0] m_ledr;
    logic [7:0]  m_ledg;
    logic [6:0]  m_hex [8];
    logic [21:0] m_deb;      // {key, sw} debounced
    logic [3:0]  m_fell;     // keys whose debounced value fell at the last edge
    logic [3:0]  m_kedge;
    logic [21:0] hist [$];   // synchronizer input samples, oldest first

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ledr  = '0;
        m_ledg  = '0;
        for (int n = 0; n < 8; n++) m_hex[n] = HEX_RST;
        m_deb   = DEB_RST;
        m_fell  = '0;
        m_kedge = '0;
        hist.delete();
        for (int j = 0; j <= N; j++) hist.push_back(DEB_RST);
    endtask

    function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
        if (a == 32'd256) m_ledr = d[17:0];
        else if (a == 32'd257) m_ledg = d[7:0];
        else if (a >= 32'd258 && a <= 32'd265) m_hex[int'(a - 32'd258)] = d[6:0] & HEX_MASK;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a == 32'd256) return {14'h0, m_ledr};
        if (a == 32'd257) return {24'h0, m_ledg};
        if (a >= 32'd258 && a <= 32'd265) return {25'h0, m_hex[int'(a - 32'd258)]};
        if (a == 32'd320) return {14'h0, m_deb[17:0]};
        if (a == 32'd321) return {28'h0, m_deb[21:18]};
        if (a == 32'd322) return {28'h0, m_kedge};
        return 32'h0;
    endfunction

    function automatic logic [55:0] exp_hex();
        logic [55:0] h;
        for (int n = 0; n < 8; n++) begin
`ifdef IO_HEX_DECODE_EN
            h[7*n +: 7] = m_hex[n][4] ? 7'h7F : seg_tab[m_hex[n][3:0]];
`else
            h[7*n +: 7] = m_hex[n];
`endif
        end
        return h;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, " sel"}, 64'(sel), 64'((addr >= 32'd256) && (addr <= 32'd383)));
        chk({tag, " dataR"}, 64'(dataR), 64'(exp_read(addr)));
        chk({tag, " ledr"}, 64'(ledr), 64'(m_ledr));
        chk({tag, " ledg"}, 64'(ledg), 64'(m_ledg));
        chk({tag, " hex"}, 64'(hex), 64'(exp_hex()));
    endtask

    task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr  = a;
        dataw = d;
        memrw = w;
        #1;
    endtask

    // One clock: model advances from pre-edge inputs; stores are single-cycle.
    task automatic tick();
        logic [21:0] flip, samp;
        logic [3:0]  set_m, clr_m;
        logic [31:0] a, d;
        logic        st;
        flip = '1;
        for (int j = 0; j < N; j++) flip &= hist[j] ^ m_deb;
        samp  = {key, sw};
        set_m = m_fell;
        a = addr; d = dataw; st = memrw;
        clr_m = (st && a == 32'd322) ? d[3:0] : 4'h0;
        @(posedge clk);
        #1;
        m_fell  = m_deb[21:18] & flip[21:18];
        m_deb   = m_deb ^ flip;
        m_kedge = (m_kedge & ~clr_m) | set_m;
        hist.push_back(samp);
        void'(hist.pop_front());
        if (st) model_store(a, d);
        memrw = 1'b0;
        #1;
        check_all("tick");
    endtask

    initial begin
        rst = 1'b1; addr = '0; dataw = '0; memrw = 1'b0; sw = '0; key = 4'hF;
        model_reset();
        #2;
        check_all("in_reset");
        #10;
        rst = 1'b0;
        tick();

        // Reset values.
        set_bus(32'd256, 0, 0); chk("rst_ledr_rd", 64'(dataR), 64'h0);
        set_bus(32'd257, 0, 0); chk("rst_ledg_rd", 64'(dataR), 64'h0);
        set_bus(32'd320, 0, 0); chk("rst_sw_rd", 64'(dataR), 64'h0);
        set_bus(32'd321, 0, 0); chk("rst_key_rd", 64'(dataR), 64'hF);
        chk("rst_hex", 64'(hex), 64'h00FF_FFFF_FFFF_FFFF);

        // LEDR truncation; same-cycle load sees old value.
        set_bus(32'd256, 32'hFFFF_FFFF, 1);
        chk("ledr_same_cycle_rd", 64'(dataR), 64'h0);
        tick();
        chk("ledr_out", 64'(ledr), 64'h3FFFF);
        set_bus(32'd256, 0, 0); chk("ledr_rd", 64'(dataR), 64'h3FFFF);
        set_bus(32'd257, 32'h1234_56A5, 1); tick();
        chk("ledg_out", 64'(ledg), 64'hA5);

        // HEX0 behaviour.
`ifdef IO_HEX_DECODE_EN
        set_bus(32'd258, 32'h3, 1); tick();
        chk("hex0_dec3", 64'(hex[6:0]), 64'h30);
        set_bus(32'd258, 32'h10, 1); tick();
        chk("hex0_blank", 64'(hex[6:0]), 64'h7F);
`else
        set_bus(32'd258, 32'h40, 1); tick();
        chk("hex0_raw", 64'(hex[6:0]), 64'h40);
`endif

        // Short switch glitch is filtered.
        sw[0] = 1'b1;
        repeat (10) tick();
        sw[0] = 1'b0;
        repeat (30) tick();
        set_bus(32'd320, 0, 0); chk("sw_glitch", 64'(dataR), 64'h0);

        // Held switch: updates on the 18th edge counting the sampling edge.
        sw[0] = 1'b1;
        repeat (17) tick();
        set_bus(32'd320, 0, 0); chk("sw_lat17", 64'(dataR), 64'h0);
        tick();
        chk("sw_lat18", 64'(dataR), 64'h1);

        // Key press sets sticky edge flag; W1C clears it.
        key[2] = 1'b0;
        repeat (25) tick();
        set_bus(32'd321, 0, 0); chk("key_rd", 64'(dataR), 64'hB);
        set_bus(32'd322, 0, 0); chk("kedge_set", 64'(dataR), 64'h4);
        set_bus(32'd322, 32'h4, 1); tick();
        chk("kedge_clr", 64'(dataR), 64'h0);
        key[2] = 1'b1;
        repeat (25) tick();
        chk("kedge_release", 64'(dataR), 64'h0);

        // New press lands on the same edge as a clear: set wins.
        key[2] = 1'b0;
        repeat (18) tick();
        set_bus(32'd321, 0, 0); chk("key_fall18", 64'(dataR), 64'hB);
        set_bus(32'd322, 0, 0); chk("kedge_pre", 64'(dataR), 64'h0);
        set_bus(32'd322, 32'h4, 1); tick();
        chk("kedge_set_wins", 64'(dataR), 64'h4);
        set_bus(32'd322, 32'hF, 1); tick();
        chk("kedge_clr2", 64'(dataR), 64'h0);

        // Out-of-window and unmapped addresses.
        set_bus(32'd384, 32'hFFFF_FFFF, 1); tick();
        set_bus(32'd300, 32'hFFFF_FFFF, 1); tick();
        set_bus(32'd383, 0, 0);  chk("sel_383", 64'(sel), 64'h1); chk("rd_383", 64'(dataR), 64'h0);
        set_bus(32'd300, 0, 0);  chk("sel_300", 64'(sel), 64'h1);
        set_bus(32'd384, 0, 0);  chk("sel_384", 64'(sel), 64'h0);
        set_bus(32'd1000, 0, 0); chk("sel_1000", 64'(sel), 64'h0); chk("rd_1000", 64'(dataR), 64'h0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin : rand_loop
            logic [31:0] a;
            if ($urandom_range(19) == 0) sw = SWW'($urandom);
            if ($urandom_range(15) == 0) key = KW'($urandom);
            case ($urandom_range(9))
                0, 1:    a = 32'd256 + $urandom_range(9);
                2:       a = 32'd320 + $urandom_range(2);
                3:       a = 32'd322;
                4:       a = 32'd256 + $urandom_range(127);
                5:       a = $urandom;
                6:       a = $urandom_range(400, 250);
                default: a = 32'd320 + $urandom_range(1);
            endcase
            set_bus(a, $urandom, 1'($urandom_range(1)));
            check_all("rand_rd");
            tick();
        end

        // Asynchronous reset mid-debounce.
        sw = 18'h3FFFF;
        key = 4'hF;
        set_bus(32'd257, 32'hFF, 1); tick();
        repeat (10) tick();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_ledg", 64'(ledg), 64'h0);
        #2;
        rst = 1'b0;
        repeat (17) tick();
        set_bus(32'd320, 0, 0); chk("post_rst_sw17", 64'(dataR), 64'h0);
        tick();
        chk("post_rst_sw18", 64'(dataR), 64'h3FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
